// File: rtl/bram_port_arbiter_if.sv
// Requester handshake and BRAM pin bundle for bram_port_arbiter.
// slave = arbiter side, master = requesters plus the BRAM itself.
interface bram_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              r0_valid, r0_we, r0_lock, r0_ready, r0_rvalid;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_valid, r1_we, r1_lock, r1_ready, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic              bram_en, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata, bram_rdata;

  modport slave (
    input  r0_valid, r0_we, r0_lock, r0_addr, r0_wdata,
    output r0_ready, r0_rvalid, r0_rdata,
    input  r1_valid, r1_we, r1_lock, r1_addr, r1_wdata,
    output r1_ready, r1_rvalid, r1_rdata,
    output bram_en, bram_we, bram_addr, bram_wdata,
    input  bram_rdata
  );

  modport master (
    output r0_valid, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r0_ready, r0_rvalid, r0_rdata,
    output r1_valid, r1_we, r1_lock, r1_addr, r1_wdata,
    input  r1_ready, r1_rvalid, r1_rdata,
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter for one single-port BRAM, with burst locking and read-owner tracking.
// Optional statistics counters are enabled by defining BRAM_ARB_STATS_EN.
module bram_port_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  bram_port_arbiter_if.slave bus
`ifdef BRAM_ARB_STATS_EN
  ,
  input  logic               stat_clr,
  output logic [31:0]        stat_r0_cnt,
  output logic [31:0]        stat_r1_cnt,
  output logic [31:0]        stat_conflict_cnt
`endif
);
  localparam int         PD        = RD_LAT + 1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  typedef enum logic [1:0] {LOCK_NONE, LOCK_R0, LOCK_R1} lock_e;

  lock_e             lock_q, lock_d;
  logic              rr_q, rr_d;
  logic [7:0]        burst_q, burst_d, burst_base;
  logic              gnt0, gnt1, force_sw, accept, win_lock, win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic              bram_en_q, bram_en_d, bram_we_q, bram_we_d;
  logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0] bram_wdata_q, bram_wdata_d;
  logic [PD-1:0]     rd_vld_q, rd_vld_d, rd_own_q, rd_own_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              rvalid0, rvalid1;

  // Burst count keeps running only while the current owner is re-granted; any other grant restarts it.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    force_sw   = 1'b0;
    rr_d       = rr_q;
    burst_base = '0;
    lock_d     = LOCK_NONE;
    burst_d    = '0;
    if (lock_q == LOCK_R0 && bus.r0_valid) begin
      if (burst_q == BURST_MAX && bus.r1_valid) begin
        gnt1     = 1'b1;
        force_sw = 1'b1;
      end else begin
        gnt0       = 1'b1;
        burst_base = burst_q;
      end
    end else if (lock_q == LOCK_R1 && bus.r1_valid) begin
      if (burst_q == BURST_MAX && bus.r0_valid) begin
        gnt0     = 1'b1;
        force_sw = 1'b1;
      end else begin
        gnt1       = 1'b1;
        burst_base = burst_q;
      end
    end else if (bus.r0_valid && bus.r1_valid) begin
      gnt0 = ~rr_q;
      gnt1 = rr_q;
      rr_d = ~rr_q;
    end else begin
      gnt0 = bus.r0_valid;
      gnt1 = bus.r1_valid;
    end
    accept   = gnt0 | gnt1;
    win_lock = gnt1 ? bus.r1_lock : bus.r0_lock;
    if (accept && !force_sw && win_lock) begin
      lock_d  = gnt1 ? LOCK_R1 : LOCK_R0;
      burst_d = (burst_base >= BURST_MAX) ? BURST_MAX : burst_base + 8'd1;
    end
  end

  always_comb begin
    win_we       = gnt1 ? bus.r1_we    : bus.r0_we;
    win_addr     = gnt1 ? bus.r1_addr  : bus.r0_addr;
    win_wdata    = gnt1 ? bus.r1_wdata : bus.r0_wdata;
    bram_en_d    = accept;
    bram_we_d    = accept & win_we;
    bram_addr_d  = accept ? win_addr  : bram_addr_q;
    bram_wdata_d = accept ? win_wdata : bram_wdata_q;
    rd_vld_d     = {rd_vld_q[PD-2:0], accept & ~win_we};
    rd_own_d     = {rd_own_q[PD-2:0], gnt1};
    rvalid0      = rd_vld_q[PD-1] & ~rd_own_q[PD-1];
    rvalid1      = rd_vld_q[PD-1] &  rd_own_q[PD-1];
    rdata0_d     = rvalid0 ? bus.bram_rdata : rdata0_q;
    rdata1_d     = rvalid1 ? bus.bram_rdata : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q       <= LOCK_NONE;
      rr_q         <= 1'b0;
      burst_q      <= '0;
      bram_en_q    <= 1'b0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      rd_vld_q     <= '0;
      rd_own_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      lock_q       <= lock_d;
      rr_q         <= rr_d;
      burst_q      <= burst_d;
      bram_en_q    <= bram_en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      rd_vld_q     <= rd_vld_d;
      rd_own_q     <= rd_own_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign bus.r0_ready   = gnt0;
  assign bus.r1_ready   = gnt1;
  assign bus.r0_rvalid  = rvalid0;
  assign bus.r1_rvalid  = rvalid1;
  assign bus.r0_rdata   = rdata0_d;
  assign bus.r1_rdata   = rdata1_d;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_wdata = bram_wdata_q;

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] st_r0_q, st_r0_d, st_r1_q, st_r1_d, st_cf_q, st_cf_d;

  always_comb begin
    st_r0_d = stat_clr ? '0 : st_r0_q + {31'd0, gnt0};
    st_r1_d = stat_clr ? '0 : st_r1_q + {31'd0, gnt1};
    st_cf_d = stat_clr ? '0 : st_cf_q + {31'd0, bus.r0_valid & bus.r1_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_r0_q <= '0;
      st_r1_q <= '0;
      st_cf_q <= '0;
    end else begin
      st_r0_q <= st_r0_d;
      st_r1_q <= st_r1_d;
      st_cf_q <= st_cf_d;
    end
  end

  assign stat_r0_cnt       = st_r0_q;
  assign stat_r1_cnt       = st_r1_q;
  assign stat_conflict_cnt = st_cf_q;
`endif
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (RD_LAT 1 and 2) share stimulus, each with its own BRAM model.
module tb_bram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int MB = 4;

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    logic          rst;
    req_t          q0;
    req_t          q1;
    logic          er0;
    logic          er1;
    int            cv;
    logic [DW-1:0] erd;
  } vec_t;

  typedef struct {
    int            due;
    int            own;
    logic [DW-1:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic stat_clr = 1'b0;
  req_t drv0, drv1, stg0, stg1, idle_r;
  logic stg_rst, stg_clr, chk_en;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
  bram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();

`define TB_DRIVE(IFC) \
  assign IFC.r0_valid = drv0.valid; assign IFC.r0_we = drv0.we; assign IFC.r0_lock = drv0.lock; \
  assign IFC.r0_addr = drv0.addr; assign IFC.r0_wdata = drv0.wdata; \
  assign IFC.r1_valid = drv1.valid; assign IFC.r1_we = drv1.we; assign IFC.r1_lock = drv1.lock; \
  assign IFC.r1_addr = drv1.addr; assign IFC.r1_wdata = drv1.wdata;
  `TB_DRIVE(ifa)
  `TB_DRIVE(ifb)

`ifdef BRAM_ARB_STATS_EN
  logic [31:0] s1_r0, s1_r1, s1_cf, s2_r0, s2_r1, s2_cf;
`endif

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_BURST(MB)) dut1 (
    .clk(clk), .rst(rst), .bus(ifa)
`ifdef BRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_r0_cnt(s1_r0), .stat_r1_cnt(s1_r1), .stat_conflict_cnt(s1_cf)
`endif
  );

  bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_BURST(MB)) dut2 (
    .clk(clk), .rst(rst), .bus(ifb)
`ifdef BRAM_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_r0_cnt(s2_r0), .stat_r1_cnt(s2_r1), .stat_conflict_cnt(s2_cf)
`endif
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 'h5a00);
  endfunction

  logic [DW-1:0] mem_a [2048];
  logic [DW-1:0] mem_b [2048];
  logic [DW-1:0] rd_a, rd_b1, rd_b2;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 2048; i++) begin
        mem_a[i] <= init_val(i);
        mem_b[i] <= init_val(i);
      end
    end else begin
      if (ifa.bram_en) begin
        if (ifa.bram_we) mem_a[ifa.bram_addr] <= ifa.bram_wdata;
        else rd_a <= mem_a[ifa.bram_addr];
      end
      if (ifb.bram_en) begin
        if (ifb.bram_we) mem_b[ifb.bram_addr] <= ifb.bram_wdata;
        else rd_b1 <= mem_b[ifb.bram_addr];
      end
      rd_b2 <= rd_b1;
    end
  end
  assign ifa.bram_rdata = rd_a;
  assign ifb.bram_rdata = rd_b2;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_rr, m_own, m_cnt, s_r0, s_r1, s_cf;
  logic e_en, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic [DW-1:0] shadow [2048];
  logic [DW-1:0] hold1 [2];
  logic [DW-1:0] hold2 [2];
  rd_t q1[$];
  rd_t q2[$];
  logic act_rdy0, act_rdy1;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t mk(input logic v, input logic l, input logic w, input int a, input int d);
    req_t r;
    r.valid = v; r.lock = l; r.we = w; r.addr = AW'(a); r.wdata = DW'(d);
    return r;
  endfunction

  function automatic req_t rand_req();
    return mk($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
              int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
  endfunction

  task automatic model_reset();
    m_rr = 0; m_own = -1; m_cnt = 0;
    e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0;
    q1.delete(); q2.delete();
    hold1 = '{default: '0}; hold2 = '{default: '0};
    s_r0 = 0; s_r1 = 0; s_cf = 0;
  endtask

  task automatic check_rd(input int lat, input logic rv0, input logic rv1,
                          input logic [DW-1:0] rd0, input logic [DW-1:0] rd1);
    logic [1:0]    erv;
    logic [DW-1:0] ed [2];
    erv = '0;
    if (lat == 1) begin
      if (q1.size() > 0 && q1[0].due == cyc) begin
        erv[q1[0].own] = 1'b1; hold1[q1[0].own] = q1[0].data; void'(q1.pop_front());
      end
      ed = hold1;
    end else begin
      if (q2.size() > 0 && q2[0].due == cyc) begin
        erv[q2[0].own] = 1'b1; hold2[q2[0].own] = q2[0].data; void'(q2.pop_front());
      end
      ed = hold2;
    end
    chk($sformatf("rvalid0_lat%0d", lat), rv0, erv[0]);
    chk($sformatf("rvalid1_lat%0d", lat), rv1, erv[1]);
    chk($sformatf("rdata0_lat%0d", lat), rd0, ed[0]);
    chk($sformatf("rdata1_lat%0d", lat), rd1, ed[1]);
  endtask

  task automatic check_outputs();
    chk("bram_en_a", ifa.bram_en, e_en);     chk("bram_en_b", ifb.bram_en, e_en);
    chk("bram_we_a", ifa.bram_we, e_we);     chk("bram_we_b", ifb.bram_we, e_we);
    chk("bram_addr_a", ifa.bram_addr, e_addr); chk("bram_addr_b", ifb.bram_addr, e_addr);
    chk("bram_wdata_a", ifa.bram_wdata, e_wd); chk("bram_wdata_b", ifb.bram_wdata, e_wd);
    check_rd(1, ifa.r0_rvalid, ifa.r1_rvalid, ifa.r0_rdata, ifa.r1_rdata);
    check_rd(2, ifb.r0_rvalid, ifb.r1_rvalid, ifb.r0_rdata, ifb.r1_rdata);
`ifdef BRAM_ARB_STATS_EN
    chk("stat_r0_a", s1_r0, s_r0); chk("stat_r1_a", s1_r1, s_r1); chk("stat_cf_a", s1_cf, s_cf);
    chk("stat_r0_b", s2_r0, s_r0); chk("stat_r1_b", s2_r1, s_r1); chk("stat_cf_b", s2_cf, s_cf);
`endif
  endtask

  // Reference arbitration: owner keeps the port unless its burst is spent and the other side waits.
  task automatic model_cycle();
    bit   v [2];
    bit   lk [2];
    req_t r;
    int   g;
    bit   forced;
    v[0] = drv0.valid; v[1] = drv1.valid; lk[0] = drv0.lock; lk[1] = drv1.lock;
    if (rst) begin
      model_reset();
      return;
    end
    g = -1; forced = 0;
    if (m_own >= 0 && v[m_own]) begin
      if (m_cnt == MB && v[1 - m_own]) begin g = 1 - m_own; forced = 1; end
      else g = m_own;
    end else if (v[0] && v[1]) begin
      g = m_rr; m_rr = 1 - m_rr;
    end else if (v[0]) g = 0;
    else if (v[1]) g = 1;
    chk("ready0_a", ifa.r0_ready, g == 0); chk("ready1_a", ifa.r1_ready, g == 1);
    chk("ready0_b", ifb.r0_ready, g == 0); chk("ready1_b", ifb.r1_ready, g == 1);
    if (g < 0 || forced || !lk[g]) begin
      m_own = -1; m_cnt = 0;
    end else begin
      m_cnt = (m_own == g) ? ((m_cnt < MB) ? m_cnt + 1 : MB) : 1;
      m_own = g;
    end
    if (g >= 0) begin
      r = (g == 1) ? drv1 : drv0;
      e_en = 1'b1; e_we = r.we; e_addr = r.addr; e_wd = r.wdata;
      if (r.we) shadow[r.addr] = r.wdata;
      else begin
        q1.push_back('{cyc + 2, g, shadow[r.addr]});
        q2.push_back('{cyc + 3, g, shadow[r.addr]});
      end
      if (g == 0) s_r0++; else s_r1++;
    end else begin
      e_en = 1'b0; e_we = 1'b0;
    end
    if (v[0] && v[1]) s_cf++;
    if (stat_clr) begin s_r0 = 0; s_r1 = 0; s_cf = 0; end
  endtask

  task automatic step();
    @(negedge clk);
    if (chk_en) check_outputs();
    drv0 = stg0; drv1 = stg1; rst = stg_rst; stat_clr = stg_clr;
    #1;
    act_rdy0 = ifa.r0_ready; act_rdy1 = ifa.r1_ready;
    model_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic add(input logic rs, input req_t a, input req_t b, input logic e0, input logic e1);
    vec_t t;
    t.rst = rs; t.q0 = a; t.q1 = b; t.er0 = e0; t.er1 = e1; t.cv = 0; t.erd = '0;
    tbl.push_back(t);
  endtask

  initial begin
    int rv_seen;
    idle_r = mk(0, 0, 0, 0, 0);
    stg0 = idle_r; stg1 = idle_r; drv0 = idle_r; drv1 = idle_r;
    stg_rst = 1'b1; stg_clr = 1'b0; chk_en = 1'b0;
    for (int i = 0; i < 2048; i++) shadow[i] = init_val(i);
    model_reset();

    // Both reads held from reset, then back-to-back writes, burst lock, lock release.
    for (int k = 0; k < 4; k++) add(0, mk(1, 0, 0, 5, 0), mk(1, 0, 0, 9, 0), k % 2 == 0, k % 2 == 1);
    tbl[1].cv = 1; tbl[1].erd = init_val(5);
    for (int k = 0; k < 3; k++) add(0, idle_r, idle_r, 0, 0);
    for (int k = 0; k < 8; k++) add(0, mk(1, 0, 1, k, 'h0100 + k), idle_r, 1, 0);
    add(0, idle_r, mk(1, 0, 0, 3, 0), 0, 1);
    for (int k = 0; k < 3; k++) add(0, idle_r, idle_r, 0, 0);
    tbl[tbl.size() - 1].cv = 2; tbl[tbl.size() - 1].erd = 16'h0103;
    add(0, idle_r, mk(1, 1, 0, 20, 0), 0, 1);
    for (int k = 0; k < 3; k++) add(0, mk(1, 0, 0, 30, 0), mk(1, 1, 0, 21 + k, 0), 0, 1);
    add(0, mk(1, 0, 0, 30, 0), mk(1, 1, 0, 24, 0), 1, 0);
    for (int k = 0; k < 2; k++) add(0, idle_r, mk(1, 1, 0, 25 + k, 0), 0, 1);
    add(0, idle_r, idle_r, 0, 0);
    add(0, mk(1, 1, 0, 40, 0), idle_r, 1, 0);
    add(0, mk(1, 0, 0, 41, 0), mk(1, 0, 0, 50, 0), 1, 0);
    add(0, idle_r, mk(1, 0, 0, 50, 0), 0, 1);
    for (int k = 0; k < 3; k++) add(0, idle_r, idle_r, 0, 0);

    step();
    chk_en = 1'b1;
    step();
    preload = 1'b0;
    stg_rst = 1'b0;

    foreach (tbl[i]) begin
      stg0 = tbl[i].q0; stg1 = tbl[i].q1; stg_rst = tbl[i].rst;
      step();
      chk("tbl_ready0", act_rdy0, tbl[i].er0);
      chk("tbl_ready1", act_rdy1, tbl[i].er1);
      if (tbl[i].cv == 1) begin
        chk("t1_r0_rvalid", ifa.r0_rvalid, 1);
        chk("t1_r0_rdata", ifa.r0_rdata, tbl[i].erd);
      end
      if (tbl[i].cv == 2) chk("t2_r1_rdata", ifa.r1_rdata, tbl[i].erd);
    end

    // Reset one cycle after a read is accepted: the read must never return.
    stg0 = mk(1, 0, 0, 10, 0); stg1 = idle_r;
    step();
    chk("t4_accept", act_rdy0, 1);
    stg0 = idle_r; stg_rst = 1'b1;
    step();
    stg_rst = 1'b0;
    chk("t4_outs_a", {ifb.r0_ready, ifb.r1_ready, ifb.r0_rvalid, ifb.r1_rvalid, ifb.bram_en,
                      ifb.bram_we, ifb.bram_addr, ifb.bram_wdata}, '0);
    chk("t4_outs_b", {ifb.r0_rdata, ifb.r1_rdata}, '0);
    rv_seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      rv_seen += int'(ifb.r0_rvalid) + int'(ifa.r0_rvalid);
    end
    chk("t4_no_rvalid", rv_seen, 0);

`ifdef BRAM_ARB_STATS_EN
    stg_rst = 1'b1; step(); stg_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin stg0 = mk(1, 0, 0, k, 0); stg1 = mk(1, 0, 0, k, 0); step(); end
    stg1 = idle_r;
    for (int k = 0; k < 8; k++) begin stg0 = mk(1, 0, 1, k, k); step(); end
    stg0 = idle_r;
    for (int k = 0; k < 2; k++) begin stg1 = mk(1, 0, 0, k, 0); step(); end
    stg1 = idle_r;
    chk("stat_r0_10", s1_r0, 10); chk("stat_r1_3", s1_r1, 3); chk("stat_cf_3", s1_cf, 3);
    stg_clr = 1'b1; step(); stg_clr = 1'b0;
    chk("stat_clr_all", {s1_r0, s1_r1, s1_cf}, '0);
`endif

    for (int i = 0; i < 3000; i++) begin
      stg0 = rand_req(); stg1 = rand_req();
      stg_rst = ($urandom_range(0, 199) == 0);
      stg_clr = ($urandom_range(0, 99) == 0);
      step();
    end
    stg0 = idle_r; stg1 = idle_r; stg_rst = 1'b0; stg_clr = 1'b0;
    for (int k = 0; k < 4; k++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port BRAM (2048 x 16 default) between two requesters, e.g. a PL write sequencer and a PL read/debug engine.
- Arbitrates round-robin per transaction, with optional burst locking.
- Drives the BRAM enable, write-enable, address and write-data pins.
- Tracks read latency so each read response returns only to its owner.

Parameters:
- ADDR_W, 11: BRAM address width (2048 words).
- DATA_W, 16: BRAM data width.
- RD_LAT, 1: BRAM read latency in cycles, legal values 1 or 2.
- MAX_BURST, 4: maximum consecutive locked grants to one requester while the other is waiting, legal range 1..255.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- r0_valid  in  1  requester 0 has a transaction.
- r0_we  in  1  1 = write, 0 = read.
- r0_lock  in  1  request to keep the grant after this transaction.
- r0_addr  in  ADDR_W  word address.
- r0_wdata  in  DATA_W  write data.
- r0_ready  out  1  transaction accepted this cycle.
- r0_rvalid  out  1  read data valid.
- r0_rdata  out  DATA_W  read data.
- r1_valid, r1_we, r1_lock, r1_addr, r1_wdata, r1_ready, r1_rvalid, r1_rdata: same as requester 0, for requester 1.
- bram_en  out  1  BRAM port enable.
- bram_we  out  1  BRAM write enable.
- bram_addr  out  ADDR_W  BRAM address.
- bram_wdata  out  DATA_W  BRAM write data.
- bram_rdata  in  DATA_W  BRAM read data, valid RD_LAT cycles after a read.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, rr pointer = requester 0 preferred, lock_owner = none, burst_cnt = 0, read pipeline flushed.
- Handshake:
  - rN_ready is combinational from the current valids and arbiter state.
  - A transaction is accepted when rN_valid & rN_ready are both 1.
  - At most one ready is high per cycle; ready never asserts without the matching valid.
- Arbitration, evaluated each cycle:
  - Locked owner: if lock_owner = N and rN_valid = 1, grant N; if rN_valid = 0, release the lock and arbitrate normally.
  - Exception: if burst_cnt = MAX_BURST and the other requester is valid, force the grant to the other requester, clear the lock, and clear burst_cnt.
  - Unlocked, one valid: grant it.
  - Unlocked, both valid: grant the rr-preferred requester, then point rr at the other.
- Lock:
  - An accepted transaction with rN_lock = 1 sets lock_owner = N and increments burst_cnt (saturating).
  - An accepted transaction with rN_lock = 0 clears lock_owner and burst_cnt.
- BRAM drive:
  - Registered; BRAM pins update on the cycle after acceptance.
  - bram_en = 1 and bram_we = accepted we; addr/wdata come from the winner.
  - bram_en = 0 on cycles with no accept.
- Reads:
  - Owner ID enters a shift pipeline of depth 1 + RD_LAT.
  - rN_rvalid pulses for 1 cycle; rN_rdata = bram_rdata; total latency from accept to rvalid = 1 + RD_LAT cycles.
  - Non-owner rdata holds its last value; rvalid stays 0.
- Writes: no response.
- Throughput: one transaction per cycle sustained; a single active requester gets back-to-back grants.
- Address wrap: none inside the block; requesters own the address sequence.
- Reset mid-operation: in-flight reads are dropped; no rvalid for 1 + RD_LAT cycles after reset.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_r0_cnt[31:0], stat_r1_cnt[31:0] (accepted transactions, wrapping) and stat_conflict_cnt[31:0] (cycles where both valid), plus input stat_clr (sync, clears all three).
  - All counters reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Both valid reads from reset, addr 5 and 9, held for 4 cycles -> ready order r0, r1, r0, r1; with RD_LAT=1, r0_rvalid at cycle 2 after first accept with data mem[5], no spurious r1_rvalid.
- r0 writes addr 0..7 data 0x0100..0x0107 back-to-back with r1 idle -> 8 consecutive ready cycles; bram_we = 1 each; r1 reads addr 3 afterward -> r1_rdata = 0x0103.
- MAX_BURST=4, r1 valid+lock for 6 transactions while r0 valid -> grants r1 x4, r0 x1, then r1 resumes; lock flag cleared at the switch.
- RD_LAT=2, r0 reads addr 10, rst asserted 1 cycle after accept -> no r0_rvalid ever; all outputs 0 the cycle after rst.
- Lock released by rN_lock = 0 on the 2nd transaction with the other requester waiting -> other requester granted on the next cycle.
- With BRAM_ARB_STATS_EN: 10 r0 accepts, 3 r1 accepts, 3 conflict cycles -> counters 10/3/3; stat_clr -> all 0 the next cycle.
